// File: rtl/lc3b_l2_nway_ctrl.sv
// rtl/lc3b_l2_nway_ctrl.sv - N-way set-associative L2 controller with per-set tree pseudo-LRU
module lc3b_l2_nway_ctrl #(
    parameter int WAYS  = 8,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_read,
    input  logic             up_write,
    input  logic [IDX_W-1:0] up_index,
    output logic             up_resp,
    input  logic [WAYS-1:0]  way_hit,
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAYS-1:0]  way_dirty,
    output logic [WAYS-1:0]  sel_way,
    output logic             load_data,
    output logic             data_src,
    output logic             load_tag,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             clr_dirty,
    output logic             wb_addr_sel,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_resp
);
    localparam int LW = $clog2(WAYS);
    localparam int NB = WAYS - 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] victim_q, victim_d;
    logic [NB-1:0] plru_q [SETS];

    logic          req;
    logic [LW-1:0] hit_idx;
    logic [LW-1:0] miss_vic;
    logic          vic_dirty;
    logic          plru_we;

    // Lowest set bit of a way vector, as a binary way index.
    function automatic logic [LW-1:0] lowest(input logic [WAYS-1:0] v);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) idx = LW'(i);
        end
        return idx;
    endfunction

    // Walk the heap from the root; node n lives at bit n-1 of the set's PLRU word.
    function automatic logic [LW-1:0] plru_pick(input logic [NB-1:0] bits);
        logic [LW:0]   node;
        logic [NB-1:0] sh;
        node = (LW+1)'(1);
        for (int l = 0; l < LW; l++) begin
            sh   = bits >> (node - 1'b1);
            node = {node[LW-1:0], sh[0]};
        end
        return node[LW-1:0];
    endfunction

    // Point every node on the path to the accessed way at the opposite subtree.
    function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits,
                                                 input logic [LW-1:0] way);
        logic [LW:0]   node;
        logic [LW-1:0] w;
        logic          d;
        logic [NB-1:0] res;
        res  = bits;
        w    = way;
        node = (LW+1)'(1);
        for (int l = 0; l < LW; l++) begin
            d    = w[LW-1];
            w    = w << 1;
            res  = (res & ~(NB'(1) << (node - 1'b1))) | (NB'(!d) << (node - 1'b1));
            node = {node[LW-1:0], d};
        end
        return res;
    endfunction

    // Hit way and miss victim selection from the datapath's per-way status.
    always_comb begin
        req       = up_read | up_write;
        hit_idx   = lowest(way_hit);
        miss_vic  = (&way_valid) ? plru_pick(plru_q[up_index]) : lowest(~way_valid);
        vic_dirty = |((WAYS'(1) << miss_vic) & way_valid & way_dirty);
    end

    // Next state and array/memory controls; everything is held at 0 while in reset.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        plru_we     = 1'b0;
        up_resp     = 1'b0;
        sel_way     = '0;
        load_data   = 1'b0;
        data_src    = 1'b0;
        load_tag    = 1'b0;
        set_valid   = 1'b0;
        set_dirty   = 1'b0;
        clr_dirty   = 1'b0;
        wb_addr_sel = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req && (|way_hit)) begin
                        sel_way   = WAYS'(1) << hit_idx;
                        up_resp   = 1'b1;
                        load_data = up_write;
                        set_dirty = up_write;
                        plru_we   = 1'b1;
                    end else if (req) begin
                        victim_d = miss_vic;
                        state_d  = vic_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    sel_way     = WAYS'(1) << victim_q;
                    mem_write   = 1'b1;
                    wb_addr_sel = 1'b1;
                    if (mem_resp) begin
                        clr_dirty = 1'b1;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    sel_way  = WAYS'(1) << victim_q;
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_data = 1'b1;
                        data_src  = 1'b1;
                        load_tag  = 1'b1;
                        set_valid = 1'b1;
                        clr_dirty = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and latched victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // PLRU bits: cleared on reset, updated only by hits taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (plru_we) begin
            plru_q[up_index] <= plru_touch(plru_q[up_index], hit_idx);
        end
    end
endmodule

// File: tb/tb_lc3b_l2_nway_ctrl.sv
// tb/tb_lc3b_l2_nway_ctrl.sv - bench for lc3b_l2_nway_ctrl with array model and PLRU reference
module tb_lc3b_l2_nway_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_read = 1'b0, up_write = 1'b0, up_resp;
    logic [2:0] up_index;
    logic [7:0] way_hit, way_valid, way_dirty, sel_way;
    logic       load_data, data_src, load_tag, set_valid, set_dirty, clr_dirty;
    logic       wb_addr_sel, mem_read, mem_write;
    logic       mem_resp = 1'b0;

    logic       q_up_read = 1'b0, q_up_write = 1'b0, q_up_resp;
    logic [2:0] q_up_index = 3'd0;
    logic [3:0] q_way_hit = 4'h0, q_way_valid = 4'h0, q_way_dirty = 4'h0, q_sel_way;
    logic       q_load_data, q_data_src, q_load_tag, q_set_valid, q_set_dirty, q_clr_dirty;
    logic       q_wb_addr_sel, q_mem_read, q_mem_write;
    logic       q_mem_resp = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_set = 0;
    int cur_tag = 0;

    bit vl [8][8];
    bit dt [8][8];
    int tg [8][8];
    int pm [8][8];

    always #5 clk = ~clk;

    lc3b_l2_nway_ctrl #(.WAYS(8), .SETS(8)) dut (
        .clk(clk), .rst_n(rst_n), .up_read(up_read), .up_write(up_write),
        .up_index(up_index), .up_resp(up_resp), .way_hit(way_hit),
        .way_valid(way_valid), .way_dirty(way_dirty), .sel_way(sel_way),
        .load_data(load_data), .data_src(data_src), .load_tag(load_tag),
        .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .wb_addr_sel(wb_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp)
    );

    lc3b_l2_nway_ctrl #(.WAYS(4), .SETS(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .up_read(q_up_read), .up_write(q_up_write),
        .up_index(q_up_index), .up_resp(q_up_resp), .way_hit(q_way_hit),
        .way_valid(q_way_valid), .way_dirty(q_way_dirty), .sel_way(q_sel_way),
        .load_data(q_load_data), .data_src(q_data_src), .load_tag(q_load_tag),
        .set_valid(q_set_valid), .set_dirty(q_set_dirty), .clr_dirty(q_clr_dirty),
        .wb_addr_sel(q_wb_addr_sel), .mem_read(q_mem_read), .mem_write(q_mem_write),
        .mem_resp(q_mem_resp)
    );

    assign up_index = 3'(cur_set);

    // Tag/valid/dirty array seen by the controller for the current request.
    always_comb begin
        way_hit   = '0;
        way_valid = '0;
        way_dirty = '0;
        for (int w = 0; w < 8; w++) begin
            way_valid[w] = vl[cur_set][w];
            way_dirty[w] = dt[cur_set][w];
            way_hit[w]   = vl[cur_set][w] && (tg[cur_set][w] == cur_tag);
        end
    end

    // Array writes commanded by the controller.
    always @(posedge clk) begin
        for (int w = 0; w < 8; w++) begin
            if (rst_n && sel_way[w]) begin
                if (load_tag)  tg[cur_set][w] <= cur_tag;
                if (set_valid) vl[cur_set][w] <= 1'b1;
                if (set_dirty) dt[cur_set][w] <= 1'b1;
                if (clr_dirty) dt[cur_set][w] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++)
            for (int n = 0; n < 8; n++) pm[s][n] = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int n;
        n = 8 + w;
        while (n > 1) begin
            pm[s][n / 2] = (n % 2 == 0) ? 1 : 0;
            n = n / 2;
        end
    endtask

    task automatic model_expect(input int s, input int t, output bit hit, output bit wb,
                                output int way);
        int n;
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < 8; w++)
            if (!hit && vl[s][w] && tg[s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
        if (!hit) begin
            for (int w = 0; w < 8; w++)
                if (way < 0 && !vl[s][w]) way = w;
            if (way < 0) begin
                n = 1;
                while (n < 8) n = 2 * n + pm[s][n];
                way = n - 8;
            end
        end
        wb = !hit && vl[s][way] && dt[s][way];
    endtask

    // Called just after a rising edge; returns just after the edge that ends the request.
    task automatic do_req(input string nm, input bit wr, input int s, input int t,
                          input int dly, input bit ehit, input bit ewb, input int eway);
        logic [7:0] eoh;
        eoh      = 8'(1) << eway;
        cur_set  = s;
        cur_tag  = t;
        up_write = wr;
        up_read  = !wr;
        mem_resp = 1'b0;
        @(negedge clk);
        if (ehit) begin
            chk({nm, " hit up_resp"}, up_resp, 1);
            chk({nm, " hit sel_way"}, sel_way, eoh);
            chk({nm, " hit load_data"}, load_data, wr);
            chk({nm, " hit data_src"}, data_src, 0);
            chk({nm, " hit set_dirty"}, set_dirty, wr);
            chk({nm, " hit mem"}, {mem_read, mem_write}, 0);
        end else begin
            chk({nm, " miss up_resp"}, up_resp, 0);
            chk({nm, " miss mem"}, {mem_read, mem_write}, 0);
            if (ewb) begin
                for (int c = 0; c < dly; c++) begin
                    @(posedge clk);
                    #1 mem_resp = (c == dly - 1);
                    @(negedge clk);
                    chk($sformatf("%s wb%0d mem", nm, c), {mem_read, mem_write}, 2'b01);
                    chk($sformatf("%s wb%0d sel_way", nm, c), sel_way, eoh);
                    chk($sformatf("%s wb%0d wb_addr_sel", nm, c), wb_addr_sel, 1);
                    chk($sformatf("%s wb%0d clr_dirty", nm, c), clr_dirty, c == dly - 1);
                    chk($sformatf("%s wb%0d up_resp", nm, c), up_resp, 0);
                end
            end
            for (int c = 0; c < dly; c++) begin
                @(posedge clk);
                #1 mem_resp = (c == dly - 1);
                @(negedge clk);
                chk($sformatf("%s fill%0d mem", nm, c), {mem_read, mem_write}, 2'b10);
                chk($sformatf("%s fill%0d sel_way", nm, c), sel_way, eoh);
                chk($sformatf("%s fill%0d wb_addr_sel", nm, c), wb_addr_sel, 0);
                chk($sformatf("%s fill%0d load", nm, c),
                    {load_tag, set_valid, load_data, data_src, clr_dirty},
                    (c == dly - 1) ? 5'h1f : 5'h00);
            end
            @(posedge clk);
            #1 mem_resp = 1'b0;
            @(negedge clk);
            chk({nm, " after-fill up_resp"}, up_resp, 1);
            chk({nm, " after-fill sel_way"}, sel_way, eoh);
            chk({nm, " after-fill load_data"}, load_data, wr);
            chk({nm, " after-fill set_dirty"}, set_dirty, wr);
            chk({nm, " after-fill mem"}, {mem_read, mem_write}, 0);
        end
        model_touch(s, eway);
        @(posedge clk);
        #1;
        up_read  = 1'b0;
        up_write = 1'b0;
    endtask

    typedef struct {
        bit wr;
        int set;
        int tag;
        int dly;
        bit hit;
        bit wb;
        int way;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit h, wbx;
        int wy, s, t, d;
        bit wr;

        tbl.push_back('{0, 3, 10, 3, 0, 0, 0});
        for (int i = 0; i < 8; i++) tbl.push_back('{0, 5, 20 + i, 2, 0, 0, i});
        tbl.push_back('{0, 5, 28, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 30, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 31, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 32, 2, 0, 0, 2});
        tbl.push_back('{1, 1, 32, 1, 1, 0, 2});
        for (int i = 0; i < 8; i++) tbl.push_back('{1, 2, 40 + i, 1, 0, 0, i});
        tbl.push_back('{1, 2, 48, 4, 0, 1, 0});
        tbl.push_back('{0, 2, 41, 1, 1, 0, 1});

        for (int s2 = 0; s2 < 8; s2++)
            for (int w = 0; w < 8; w++) begin
                vl[s2][w] = 1'b0;
                dt[s2][w] = 1'b0;
                tg[s2][w] = -1;
            end
        model_clear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {up_resp, sel_way, load_data, data_src, load_tag, set_valid,
                              set_dirty, clr_dirty, wb_addr_sel, mem_read, mem_write}, 0);
        chk("reset outputs w4", {q_up_resp, q_sel_way, q_load_data, q_mem_read, q_mem_write}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle no request", {up_resp, sel_way, mem_read, mem_write, load_data}, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            do_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].set, tbl[i].tag, tbl[i].dly,
                   tbl[i].hit, tbl[i].wb, tbl[i].way);

        cur_set = 5;
        cur_tag = 99;
        up_read = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre-reset mem_read", mem_read, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset mem_read", {mem_read, mem_write}, 0);
        chk("async reset sel_way", sel_way, 0);
        up_read = 1'b0;
        model_clear();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req("post-reset", 0, 5, 99, 2, 0, 0, 0);

        q_up_read   = 1'b1;
        q_way_valid = 4'hf;
        q_way_hit   = 4'b0001;
        @(negedge clk);
        chk("w4 hit0 resp", {q_up_resp, q_sel_way}, {1'b1, 4'b0001});
        @(posedge clk);
        #1 q_way_hit = 4'b0100;
        @(negedge clk);
        chk("w4 hit2 resp", {q_up_resp, q_sel_way}, {1'b1, 4'b0100});
        @(posedge clk);
        #1 q_way_hit = 4'b0000;
        @(negedge clk);
        chk("w4 miss resp", {q_up_resp, q_mem_read, q_mem_write}, 0);
        @(posedge clk);
        #1 q_mem_resp = 1'b1;
        @(negedge clk);
        chk("w4 victim", {q_mem_read, q_sel_way}, {1'b1, 4'b0010});
        @(posedge clk);
        #1;
        q_mem_resp = 1'b0;
        q_up_read  = 1'b0;
        @(negedge clk);
        chk("w4 mem_read drop", q_mem_read, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            s  = int'($urandom_range(0, 7));
            t  = int'($urandom_range(0, 11));
            d  = int'($urandom_range(1, 4));
            wr = 1'($urandom_range(0, 1));
            model_expect(s, t, h, wbx, wy);
            do_req($sformatf("rnd%0d", i), wr, s, t, d, h, wbx, wy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
